// File: rtl/hdc_msg_sequencer.sv
// Sequences one message through the HDC encode/classify datapath.
// A message is captured on a start handshake and streamed to the encoder one
// character at a time. Characters that complete an n-gram are flagged. The
// similarity compare is then triggered, and its label is returned on a
// valid/ready port.
module hdc_msg_sequencer #(
  parameter int MESSAGE_LENGTH = 200,
  parameter int CHAR_LENGTH    = 8,
  parameter int NGRAM          = 3,
  parameter int CMP_TIMEOUT    = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start_valid,
  output logic                                  start_ready,
  input  logic [CHAR_LENGTH*MESSAGE_LENGTH-1:0] msg,
  input  logic [7:0]                            length,
  output logic                                  char_valid,
  input  logic                                  char_ready,
  output logic [CHAR_LENGTH-1:0]                char_data,
  output logic                                  ngram_en,
  output logic                                  acc_clear,
  output logic                                  cmp_start,
  input  logic                                  cmp_done,
  input  logic [1:0]                            cmp_result,
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic [1:0]                            result,
  output logic                                  busy
);

  localparam int IDX_W = $clog2(MESSAGE_LENGTH);
  localparam int TO_W  = $clog2(CMP_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_CMP,
    S_WAIT_CMP,
    S_DONE
  } state_t;

  state_t                                state_q, state_d;
  logic [CHAR_LENGTH*MESSAGE_LENGTH-1:0] msg_q, msg_d;
  logic [7:0]                            len_q, len_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic [TO_W-1:0]                       to_q, to_d;
  logic [1:0]                            result_q, result_d;
  logic [7:0]                            len_eff;
  logic [CHAR_LENGTH-1:0]                cur_char;

  // Select the buffered character at the current stream index
  always_comb begin
    cur_char = '0;
    for (int i = 0; i < MESSAGE_LENGTH; i++) begin
      if (idx_q == IDX_W'(i)) cur_char = msg_q[i*CHAR_LENGTH +: CHAR_LENGTH];
    end
  end

  // Next-state logic and Moore outputs of the message sequencer
  always_comb begin
    state_d      = state_q;
    msg_d        = msg_q;
    len_d        = len_q;
    idx_d        = idx_q;
    to_d         = to_q;
    result_d     = result_q;
    start_ready  = 1'b0;
    char_valid   = 1'b0;
    char_data    = '0;
    ngram_en     = 1'b0;
    acc_clear    = 1'b0;
    cmp_start    = 1'b0;
    result_valid = 1'b0;
    result       = 2'b00;
    busy         = (state_q != S_IDLE);
    len_eff      = (int'(length) > MESSAGE_LENGTH) ? 8'(MESSAGE_LENGTH) : length;
    case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          msg_d   = msg;
          len_d   = len_eff;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        acc_clear = 1'b1;
        idx_d     = '0;
        if (int'(len_q) < NGRAM) begin
          result_d = 2'b11;
          state_d  = S_DONE;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        char_valid = 1'b1;
        char_data  = cur_char;
        ngram_en   = (int'(idx_q) >= NGRAM - 1);
        if (char_ready) begin
          if (int'(idx_q) == int'(len_q) - 1) state_d = S_CMP;
          else                                idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_CMP: begin
        cmp_start = 1'b1;
        to_d      = '0;
        state_d   = S_WAIT_CMP;
      end
      S_WAIT_CMP: begin
        if (cmp_done) begin
          result_d = cmp_result;
          state_d  = S_DONE;
        end else if (int'(to_q) == CMP_TIMEOUT - 1) begin
          result_d = 2'b11;
          state_d  = S_DONE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_DONE: begin
        result_valid = 1'b1;
        result       = result_q;
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      msg_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      to_q     <= '0;
      result_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      to_q     <= to_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_hdc_msg_sequencer.sv
// Self-checking bench for hdc_msg_sequencer: directed and randomized messages
// checked cycle by cycle against a transaction-level reference model.
module tb_hdc_msg_sequencer;

  localparam int ML = 200;
  localparam int CL = 8;
  localparam int NG = 3;
  localparam int TO = 64;

  logic            clk;
  logic            reset;
  logic            start_valid;
  logic            start_ready;
  logic [ML*CL-1:0] msg;
  logic [7:0]      length;
  logic            char_valid;
  logic            char_ready;
  logic [CL-1:0]   char_data;
  logic            ngram_en;
  logic            acc_clear;
  logic            cmp_start;
  logic            cmp_done;
  logic [1:0]      cmp_result;
  logic            result_valid;
  logic            result_ready;
  logic [1:0]      result;
  logic            busy;

  int vectors;
  int miscompares;

  hdc_msg_sequencer #(
    .MESSAGE_LENGTH(ML),
    .CHAR_LENGTH(CL),
    .NGRAM(NG),
    .CMP_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .msg(msg),
    .length(length),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .char_data(char_data),
    .ngram_en(ngram_en),
    .acc_clear(acc_clear),
    .cmp_start(cmp_start),
    .cmp_done(cmp_done),
    .cmp_result(cmp_result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result(result),
    .busy(busy)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".start_ready"}, 32'(start_ready), 1);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".char_valid"}, 32'(char_valid), 0);
    check({tag, ".char_data"}, 32'(char_data), 0);
    check({tag, ".ngram_en"}, 32'(ngram_en), 0);
    check({tag, ".acc_clear"}, 32'(acc_clear), 0);
    check({tag, ".cmp_start"}, 32'(cmp_start), 0);
    check({tag, ".result_valid"}, 32'(result_valid), 0);
    check({tag, ".result"}, 32'(result), 0);
  endtask

  function automatic logic [ML*CL-1:0] rand_msg();
    logic [ML*CL-1:0] m;
    for (int i = 0; i < ML*CL/32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [ML*CL-1:0] str_msg(input string s);
    logic [ML*CL-1:0] m;
    m = rand_msg();
    for (int i = 0; i < s.len(); i++) m[i*CL +: CL] = s[i];
    return m;
  endfunction

  // One message transaction. rmode: 0 always ready, 1 alternating 1,0,...,
  // 2 random. d: cycles after the cmp_start cycle at which cmp_done pulses
  // (negative = never). rr_delay: cycles result_ready is withheld.
  // abort_t: cycle at which reset is pulsed (0 = never).
  task automatic applyStimulus(input string name, input logic [ML*CL-1:0] m, input logic [7:0] len,
                               input int rmode, input int d, input logic [1:0] cval,
                               input int rr_delay, input int abort_t);
    int len_eff, exp_n, t, acc, cmp_t, res_t, done_t, s;
    logic [1:0] exp_res;
    logic exp_cv, exp_rv, rdy, cmp_ok;
    len_eff = (int'(len) > ML) ? ML : int'(len);
    exp_n   = (len_eff < NG) ? 0 : len_eff;
    cmp_ok  = (d >= 1 && d <= TO);
    exp_res = (exp_n == 0) ? 2'b11 : (cmp_ok ? cval : 2'b11);
    @(negedge clk);
    check({name, ".start_ready0"}, 32'(start_ready), 1);
    start_valid = 1'b1;
    msg         = m;
    length      = len;
    cmp_result  = cval;
    t = 0; acc = 0; cmp_t = 0; done_t = 0; s = 0;
    res_t = (exp_n == 0) ? 2 : (1 << 30);
    while (1) begin
      @(negedge clk);
      t++;
      if (t == 1) begin
        start_valid = 1'b0;
        msg         = rand_msg();
        length      = 8'($urandom);
      end
      if (t > 2000) begin
        vectors++;
        miscompares++;
        $error("[TB] FAIL %s.bound observed=%0d expected=<2000 cycles", name, t);
        break;
      end
      exp_cv = (exp_n > 0) && (t >= 2) && (acc < exp_n);
      exp_rv = (t >= res_t) && (done_t == 0);
      check({name, ".busy"}, 32'(busy), 32'(done_t == 0));
      check({name, ".start_ready"}, 32'(start_ready), 32'(done_t != 0));
      check({name, ".acc_clear"}, 32'(acc_clear), 32'(t == 1));
      check({name, ".char_valid"}, 32'(char_valid), 32'(exp_cv));
      check({name, ".char_data"}, 32'(char_data), exp_cv ? 32'(m[acc*CL +: CL]) : 0);
      check({name, ".ngram_en"}, 32'(ngram_en), 32'(exp_cv && acc >= NG - 1));
      check({name, ".cmp_start"}, 32'(cmp_start), 32'(cmp_t != 0 && t == cmp_t));
      check({name, ".result_valid"}, 32'(result_valid), 32'(exp_rv));
      check({name, ".result"}, 32'(result), exp_rv ? 32'(exp_res) : 0);
      if (done_t != 0) break;
      if (t == abort_t) begin
        reset = 1'b0;
        #1;
        check_idle({name, ".abort"});
        #1;
        reset = 1'b1;
        break;
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = exp_cv ? (s % 2 == 0) : 1'b0;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (exp_cv) s++;
      char_ready = rdy;
      if (exp_cv && rdy) begin
        acc++;
        if (acc == exp_n) begin
          cmp_t = t + 1;
          res_t = cmp_t + (cmp_ok ? d : TO) + 1;
        end
      end
      cmp_done     = (cmp_t != 0 && t == cmp_t + d);
      result_ready = (t >= res_t + rr_delay);
      if (exp_rv && result_ready) done_t = t;
    end
    char_ready   = 1'b0;
    cmp_done     = 1'b0;
    result_ready = 1'b0;
  endtask

  task automatic checkOutput(input string name);
    @(negedge clk);
    check_idle(name);
  endtask

  initial begin
    logic [ML*CL-1:0] hello;
    logic [1:0] cvals [3];
    vectors      = 0;
    miscompares  = 0;
    cvals[0] = 2'b00; cvals[1] = 2'b01; cvals[2] = 2'b11;
    reset        = 1'b0;
    start_valid  = 1'b0;
    msg          = '0;
    length       = 8'd0;
    char_ready   = 1'b0;
    cmp_done     = 1'b0;
    cmp_result   = 2'b00;
    result_ready = 1'b0;
    #2;
    check_idle("reset_active");
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    checkOutput("reset_released");

    hello = str_msg("hello");
    applyStimulus("hello_basic", hello, 8'd5, 0, 2, 2'b01, 0, 0);
    applyStimulus("hello_stall", hello, 8'd5, 1, 3, 2'b00, 0, 0);
    applyStimulus("len0", rand_msg(), 8'd0, 0, 2, 2'b01, 0, 0);
    applyStimulus("len2", rand_msg(), 8'd2, 0, 2, 2'b01, 0, 0);
    applyStimulus("len3", rand_msg(), 8'd3, 0, 1, 2'b00, 0, 0);
    applyStimulus("len250", rand_msg(), 8'd250, 0, 5, 2'b01, 0, 0);
    applyStimulus("len200_stall", rand_msg(), 8'd200, 1, 4, 2'b00, 0, 0);
    applyStimulus("timeout", hello, 8'd5, 0, -1, 2'b01, 0, 0);
    applyStimulus("done_last_cycle", hello, 8'd5, 0, TO, 2'b00, 0, 0);
    applyStimulus("done_too_late", hello, 8'd5, 0, TO + 1, 2'b01, 0, 0);
    applyStimulus("done_in_cmp", hello, 8'd5, 0, 0, 2'b01, 0, 0);
    applyStimulus("abort", hello, 8'd5, 0, 2, 2'b01, 0, 4);
    checkOutput("after_abort");
    applyStimulus("hello_rerun", hello, 8'd5, 0, 2, 2'b01, 0, 0);
    applyStimulus("result_hold", hello, 8'd5, 0, 2, 2'b01, 10, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("rand%0d", i), rand_msg(), 8'($urandom_range(0, 255)), 2,
                    int'($urandom_range(1, 70)), cvals[$urandom_range(0, 2)],
                    int'($urandom_range(0, 3)), 0);
    end
    checkOutput("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
